// File: rtl/dl_ctrl_pkg.sv
// Shared types and helpers for the delay-line sequencer and its position counter.
// ST_VERIFY exists only when DL_CTRL_VERIFY_EN is defined.
package dl_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } dl_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_XFER,
`ifdef DL_CTRL_VERIFY_EN
        ST_CLEAR,
        ST_VERIFY
`else
        ST_CLEAR
`endif
    } dl_state_e;

    // One revolution: cycles for a bit to travel once around the line.
    function automatic int dl_revolution(input int store_len, input int word_width);
        return store_len * word_width;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Behavioural recirculating delay line of LEN bits (LEN >= 2).
// A bit entered in one cycle re-emerges on data_out exactly LEN cycles later.
module delay_line #(
    parameter int LEN = 576
)(
    input  logic clk,
    input  logic data_in,
    input  logic data_in_gate,
    input  logic data_clr,
    output logic data_out
);
    logic [LEN-1:0] r_store;
    logic           w_next;

    always_comb begin
        w_next = data_in_gate ? data_in : data_out;
        if (!data_clr) w_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        r_store <= {r_store[LEN-2:0], w_next};
    end

    assign data_out = r_store[LEN-1];
endmodule

// File: rtl/dl_position_counter.sv
// Tracks the word/bit currently emerging from the line and flags the cycle
// just before slot(i_addr) begins.
module dl_position_counter #(
    parameter int STORE_LEN  = 32,
    parameter int WORD_WIDTH = 18,
    parameter int ADDR_W     = 5,
    parameter int BIT_W      = 5
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [BIT_W-1:0]  o_bit_cnt,
    output logic [ADDR_W-1:0] o_word_cnt,
    output logic              o_slot_start_next
);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(STORE_LEN - 1);

    logic [BIT_W-1:0]  r_bit;
    logic [ADDR_W-1:0] r_word;
    logic              w_bit_wrap;
    logic [ADDR_W-1:0] w_word_next;

    assign w_bit_wrap  = (r_bit == BIT_LAST);
    assign w_word_next = (r_word == WORD_LAST) ? '0 : r_word + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit  <= '0;
            r_word <= '0;
        end else if (w_bit_wrap) begin
            r_bit  <= '0;
            r_word <= w_word_next;
        end else begin
            r_bit  <= r_bit + BIT_W'(1);
        end
    end

    assign o_bit_cnt         = r_bit;
    assign o_word_cnt        = r_word;
    assign o_slot_start_next = w_bit_wrap && (w_word_next == i_addr);
endmodule

// File: rtl/delay_line_ctrl.sv
// Word-level read/write/clear sequencer for one recirculating delay-line store.
// DL_CTRL_VERIFY_EN adds a read-back of every write one revolution later.
//
// state  | meaning
// IDLE   | ready for a request (held off during the rsp_valid cycle)
// SEEK   | waiting for slot(addr) to reach the line output
// XFER   | one word slot: drive bits on write, capture bits on read
// CLEAR  | data_clr held low for one full revolution
// VERIFY | write read-back during slot(addr) one revolution later
module delay_line_ctrl
    import dl_ctrl_pkg::*;
#(
    parameter int STORE_LEN  = 32,
    parameter int WORD_WIDTH = 18,
    parameter int ADDR_W     = 5
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  dl_data_in,
    output logic                  dl_data_in_gate,
    output logic                  dl_data_clr,
    input  logic                  dl_data_out,
    output logic [ADDR_W-1:0]     pos_word
);
    localparam int R  = dl_revolution(STORE_LEN, WORD_WIDTH);
    localparam int BW = $clog2(WORD_WIDTH);
    localparam int CW = $clog2(R + 1);
    localparam logic [ADDR_W:0]   LEN_W    = (ADDR_W + 1)'(STORE_LEN);
    localparam logic [BW-1:0]     BIT_LAST = BW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0]     CLR_LOAD = CW'(R - 1);

    dl_state_e             r_state, w_state_next;
    logic                  r_is_write;
    logic [ADDR_W-1:0]     r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic [CW-1:0]         r_clr_cnt;
    logic                  r_rsp_valid;
    logic [WORD_WIDTH-1:0] r_rsp_rdata;

    logic [BW-1:0]         w_bit_cnt;
    logic [ADDR_W-1:0]     w_word_cnt;
    logic [ADDR_W-1:0]     w_seek_addr;
    logic                  w_slot_next;
    logic                  w_accept;
    logic                  w_addr_ok;
    logic                  w_rsp_fire;
    logic                  w_rsp_data_en;
    logic                  w_capture;
    logic [WORD_WIDTH-1:0] w_rdata_cap;

    // In IDLE the incoming address is checked so an aligned request skips SEEK.
    assign w_seek_addr = (r_state == ST_IDLE) ? req_addr : r_addr;

    dl_position_counter #(
        .STORE_LEN  (STORE_LEN),
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_W     (ADDR_W),
        .BIT_W      (BW)
    ) u_pos (
        .clk               (clk),
        .rst               (rst),
        .i_addr            (w_seek_addr),
        .o_bit_cnt         (w_bit_cnt),
        .o_word_cnt        (w_word_cnt),
        .o_slot_start_next (w_slot_next)
    );

    assign req_ready = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_accept  = req_valid && req_ready;
    assign w_addr_ok = ({1'b0, req_addr} < LEN_W);

    always_comb begin
        w_state_next    = r_state;
        dl_data_in      = 1'b0;
        dl_data_in_gate = 1'b0;
        dl_data_clr     = 1'b1;
        w_rsp_fire      = 1'b0;
        w_rsp_data_en   = 1'b0;
        w_capture       = 1'b0;
        w_rdata_cap            = r_rdata;
        w_rdata_cap[w_bit_cnt] = dl_data_out;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_op == OP_CLEAR)  w_state_next = ST_CLEAR;
                    else if (!w_addr_ok)     w_rsp_fire   = 1'b1;
                    else if (w_slot_next)    w_state_next = ST_XFER;
                    else                     w_state_next = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (w_slot_next) w_state_next = ST_XFER;
            end
            ST_XFER: begin
                if (r_is_write) begin
                    dl_data_in_gate = 1'b1;
                    dl_data_in      = r_wdata[w_bit_cnt];
                end else begin
                    w_capture = 1'b1;
                end
                if (w_bit_cnt == BIT_LAST) begin
`ifdef DL_CTRL_VERIFY_EN
                    if (r_is_write) begin
                        w_state_next = ST_VERIFY;
                    end else begin
                        w_state_next  = ST_IDLE;
                        w_rsp_fire    = 1'b1;
                        w_rsp_data_en = 1'b1;
                    end
`else
                    w_state_next  = ST_IDLE;
                    w_rsp_fire    = 1'b1;
                    w_rsp_data_en = !r_is_write;
`endif
                end
            end
            ST_CLEAR: begin
                dl_data_clr = 1'b0;
                if (r_clr_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_rsp_fire   = 1'b1;
                end
            end
`ifdef DL_CTRL_VERIFY_EN
            ST_VERIFY: begin
                if (w_word_cnt == r_addr) begin
                    w_capture = 1'b1;
                    if (w_bit_cnt == BIT_LAST) begin
                        w_state_next  = ST_IDLE;
                        w_rsp_fire    = 1'b1;
                        w_rsp_data_en = 1'b1;
                    end
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_clr_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rsp_valid <= w_rsp_fire;
            r_rsp_rdata <= w_rsp_data_en ? w_rdata_cap : '0;
            if (w_accept) begin
                r_is_write <= (req_op == OP_WRITE);
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_clr_cnt  <= CLR_LOAD;
            end
            if (w_capture) r_rdata <= w_rdata_cap;
            if (r_state == ST_CLEAR && r_clr_cnt != '0) r_clr_cnt <= r_clr_cnt - CW'(1);
        end
    end

`ifdef DL_CTRL_VERIFY_EN
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) r_rsp_err <= 1'b0;
        else     r_rsp_err <= w_rsp_data_en && r_is_write && (w_rdata_cap != r_wdata);
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign pos_word  = w_word_cnt;
endmodule
